usb_sniffer_capture: RTL and testbench

Front-end capture stage of the USB sniffer. It observes the UTMI receive interface and encodes bus activity into 32-bit log records: packet start with PID and timestamp, packed payload bytes, packet end with status, and line-state changes. Records go through a valid/accept handshake into the downstream 32-bit capture FIFO (`push`/`accept`). A small internal queue absorbs short stalls, and any record that cannot be queued is counted as an overflow.

---
 rtl/usb_sniffer_pkg.sv | 60 ++++++
 rtl/usb_sniffer_capture_q.sv | 56 +++++
 rtl/usb_sniffer_capture.sv | 184 ++++++++++++++++++
 tb/tb_usb_sniffer_capture.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/usb_sniffer_pkg.sv
// Shared record encoding, field positions and FSM states for the USB sniffer capture front end.
package usb_sniffer_pkg;

    localparam logic [1:0] REC_LINE  = 2'b00;
    localparam logic [1:0] REC_START = 2'b01;
    localparam logic [1:0] REC_DATA  = 2'b10;
    localparam logic [1:0] REC_END   = 2'b11;

    localparam int REC_TYPE_LSB  = 30;
    localparam int LINE_OVF_BIT  = 18;
    localparam int LINE_LS_LSB   = 16;
    localparam int START_PID_LSB = 16;
    localparam int DATA_CNT_LSB  = 24;
    localparam int END_ERR_BIT   = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PID  = 2'd1,
        ST_DATA = 2'd2,
        ST_END  = 2'd3
    } state_t;

    function automatic logic [31:0] mk_line(input logic ovf, input logic [1:0] ls, input logic [15:0] ts);
        logic [31:0] r;
        r = '0;
        r[REC_TYPE_LSB +: 2]  = REC_LINE;
        r[LINE_OVF_BIT]       = ovf;
        r[LINE_LS_LSB +: 2]   = ls;
        r[15:0]               = ts;
        return r;
    endfunction

    function automatic logic [31:0] mk_start(input logic [7:0] pid, input logic [15:0] ts);
        logic [31:0] r;
        r = '0;
        r[REC_TYPE_LSB +: 2]  = REC_START;
        r[START_PID_LSB +: 8] = pid;
        r[15:0]               = ts;
        return r;
    endfunction

    function automatic logic [31:0] mk_data(input logic [1:0] cnt, input logic [23:0] bytes);
        logic [31:0] r;
        r = '0;
        r[REC_TYPE_LSB +: 2]  = REC_DATA;
        r[DATA_CNT_LSB +: 2]  = cnt;
        r[23:0]               = bytes;
        return r;
    endfunction

    function automatic logic [31:0] mk_end(input logic err, input logic [15:0] len);
        logic [31:0] r;
        r = '0;
        r[REC_TYPE_LSB +: 2]  = REC_END;
        r[END_ERR_BIT]        = err;
        r[15:0]               = len;
        return r;
    endfunction

endpackage

// File: rtl/usb_sniffer_capture_q.sv
// Small register FIFO for log records; an enqueue that finds no room is dropped and flagged.
module usb_sniffer_capture_q #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         enq_i,
    input  logic [W-1:0] data_i,
    input  logic         deq_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_deq;
    logic          w_wr;

    assign full_o  = (r_count == CNT_FULL);
    assign empty_o = (r_count == '0);
    assign data_o  = r_mem[r_rptr];
    assign w_deq   = deq_i & ~empty_o;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign w_wr    = enq_i & (~full_o | w_deq);
    assign drop_o  = enq_i & full_o & ~w_deq;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= data_i;
                r_wptr        <= r_wptr + PTR_ONE;
            end
            if (w_deq) r_rptr <= r_rptr + PTR_ONE;
            case ({w_wr, w_deq})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/usb_sniffer_capture.sv
// UTMI receive observer: encodes packets and line-state changes into 32-bit log records for the capture FIFO.
module usb_sniffer_capture
    import usb_sniffer_pkg::*;
#(
    parameter int QUEUE_DEPTH = 4,
    parameter int TS_W        = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic [7:0]  utmi_data_i,
    input  logic        utmi_rxvalid_i,
    input  logic        utmi_rxactive_i,
    input  logic        utmi_rxerror_i,
    input  logic [1:0]  utmi_linestate_i,
    output logic [31:0] data_o,
    output logic        push_o,
    input  logic        accept_i,
    output logic        overflow_o,
    output logic [15:0] drop_count_o
);
    localparam logic [TS_W-1:0] TS_ONE = TS_W'(1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_rxact_d;
    logic [1:0]      r_ls;
    logic [TS_W-1:0] r_ts;
    logic [15:0]     r_len;
    logic            r_err;
    logic [23:0]     r_pack;
    logic [1:0]      r_cnt;
    logic            r_ovf_pend;
    logic            r_overflow;
    logic [15:0]     r_drop_cnt;

    logic            w_rise;
    logic            w_ls_chg;
    logic            w_byte;
    logic            w_err_now;
    logic [15:0]     w_ts16;
    logic            w_enq;
    logic            w_is_line;
    logic            w_reload_ts;
    logic [31:0]     w_rec;
    logic            w_drop;
    logic            w_empty;
    logic            w_full_unused;

    assign w_rise    = utmi_rxactive_i & ~r_rxact_d;
    assign w_ls_chg  = (utmi_linestate_i != r_ls);
    assign w_byte    = utmi_rxactive_i & utmi_rxvalid_i;
    assign w_err_now = r_err | utmi_rxerror_i;
    assign w_ts16    = 16'(r_ts);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (enable_i && w_rise) w_state_nxt = ST_PID;
            ST_PID:  if (!utmi_rxactive_i) w_state_nxt = ST_IDLE;
                     else if (utmi_rxvalid_i) w_state_nxt = ST_DATA;
            ST_DATA: if (!utmi_rxactive_i) w_state_nxt = (r_cnt != 2'd0) ? ST_END : ST_IDLE;
            ST_END:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_enq       = 1'b0;
        w_is_line   = 1'b0;
        w_reload_ts = 1'b0;
        w_rec       = '0;
        case (r_state)
            ST_IDLE: if (enable_i && !utmi_rxactive_i && w_ls_chg) begin
                w_enq       = 1'b1;
                w_is_line   = 1'b1;
                w_reload_ts = 1'b1;
                w_rec       = mk_line(r_ovf_pend, utmi_linestate_i, w_ts16);
            end
            ST_PID: if (!utmi_rxactive_i) begin
                w_enq = 1'b1;
                w_rec = mk_end(w_err_now, r_len);
            end else if (utmi_rxvalid_i) begin
                w_enq       = 1'b1;
                w_reload_ts = 1'b1;
                w_rec       = mk_start(utmi_data_i, w_ts16);
            end
            ST_DATA: if (!utmi_rxactive_i) begin
                w_enq = 1'b1;
                w_rec = (r_cnt != 2'd0) ? mk_data(r_cnt, r_pack) : mk_end(w_err_now, r_len);
            end else if (utmi_rxvalid_i && r_cnt == 2'd2) begin
                w_enq = 1'b1;
                w_rec = mk_data(2'd3, {utmi_data_i, r_pack[15:0]});
            end
            ST_END: begin
                w_enq = 1'b1;
                w_rec = mk_end(r_err, r_len);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rxact_d <= 1'b0;
            r_ls      <= 2'b00;
            r_ts      <= '0;
        end else begin
            r_rxact_d <= utmi_rxactive_i;
            // A packet starting alongside a line change absorbs the change silently.
            if (r_state == ST_IDLE && enable_i && (!utmi_rxactive_i || w_rise))
                r_ls <= utmi_linestate_i;
            if (w_reload_ts)     r_ts <= TS_ONE;
            else if (r_ts != '1) r_ts <= r_ts + TS_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_len  <= '0;
            r_err  <= 1'b0;
            r_pack <= '0;
            r_cnt  <= '0;
        end else begin
            if (r_state == ST_IDLE && enable_i && w_rise) begin
                r_len  <= '0;
                r_err  <= 1'b0;
                r_pack <= '0;
                r_cnt  <= '0;
            end
            if ((r_state == ST_PID || r_state == ST_DATA) && utmi_rxerror_i) r_err <= 1'b1;
            if (r_state == ST_PID && w_byte) r_len <= 16'd1;
            if (r_state == ST_DATA && w_byte) begin
                if (r_len != '1) r_len <= r_len + 16'd1;
                case (r_cnt)
                    2'd0: begin r_pack[7:0]  <= utmi_data_i; r_cnt <= 2'd1; end
                    2'd1: begin r_pack[15:8] <= utmi_data_i; r_cnt <= 2'd2; end
                    default: begin r_pack <= '0; r_cnt <= 2'd0; end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ovf_pend <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_drop) begin
                r_ovf_pend <= 1'b1;
                r_overflow <= 1'b1;
                if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
            end else if (w_is_line) begin
                r_ovf_pend <= 1'b0;
            end
        end
    end

    usb_sniffer_capture_q #(
        .DEPTH (QUEUE_DEPTH),
        .W     (32)
    ) u_q (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .enq_i   (w_enq),
        .data_i  (w_rec),
        .deq_i   (accept_i),
        .data_o  (data_o),
        .full_o  (w_full_unused),
        .empty_o (w_empty),
        .drop_o  (w_drop)
    );

    assign push_o       = ~w_empty;
    assign overflow_o   = r_overflow;
    assign drop_count_o = r_drop_cnt;

endmodule

// File: tb/tb_usb_sniffer_capture.sv
// Directed bench for usb_sniffer_capture: packet encoding, line-state logging, overflow and reset behaviour.
module tb_usb_sniffer_capture;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        enable_i;
    logic [7:0]  utmi_data_i;
    logic        utmi_rxvalid_i;
    logic        utmi_rxactive_i;
    logic        utmi_rxerror_i;
    logic [1:0]  utmi_linestate_i;
    logic [31:0] data_o;
    logic        push_o;
    logic        accept_i;
    logic        overflow_o;
    logic [15:0] drop_count_o;

    int total = 0;
    int bad   = 0;
    int err_idx;
    logic [31:0] got [$];
    logic [7:0]  pkt_q [$];
    logic [31:0] w;

    usb_sniffer_capture #(.QUEUE_DEPTH(4), .TS_W(16)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .enable_i         (enable_i),
        .utmi_data_i      (utmi_data_i),
        .utmi_rxvalid_i   (utmi_rxvalid_i),
        .utmi_rxactive_i  (utmi_rxactive_i),
        .utmi_rxerror_i   (utmi_rxerror_i),
        .utmi_linestate_i (utmi_linestate_i),
        .data_o           (data_o),
        .push_o           (push_o),
        .accept_i         (accept_i),
        .overflow_o       (overflow_o),
        .drop_count_o     (drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Words handed to the FIFO are collected mid-cycle, while inputs are stable.
    always @(negedge clk_i) begin
        if (rst_ni && push_o && accept_i) got.push_back(data_o);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pop_word(output logic [31:0] v);
        if (got.size() > 0) v = got.pop_front();
        else                v = 'x;
    endtask

    // Rise, one byte per cycle from pkt_q (rxerror on byte err_idx), then fall.
    task automatic run_packet();
        utmi_rxactive_i = 1'b1;
        step();
        for (int i = 0; i < pkt_q.size(); i++) begin
            utmi_rxvalid_i = 1'b1;
            utmi_data_i    = pkt_q[i];
            utmi_rxerror_i = (i == err_idx);
            step();
        end
        utmi_rxvalid_i  = 1'b0;
        utmi_rxerror_i  = 1'b0;
        utmi_data_i     = 8'h00;
        utmi_rxactive_i = 1'b0;
        step();
    endtask

    initial begin
        rst_ni           = 1'b0;
        enable_i         = 1'b1;
        utmi_data_i      = 8'h00;
        utmi_rxvalid_i   = 1'b0;
        utmi_rxactive_i  = 1'b0;
        utmi_rxerror_i   = 1'b0;
        utmi_linestate_i = 2'b00;
        accept_i         = 1'b1;
        err_idx          = -1;
        repeat (3) step();

        chk("rst_push", 32'(push_o), 32'd0);
        chk("rst_data", data_o, 32'h0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rst_drops", 32'(drop_count_o), 32'd0);

        // Basic packet after 10 idle cycles
        rst_ni = 1'b1;
        repeat (10) step();
        pkt_q = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h44};
        run_packet();
        repeat (5) step();
        chk("pkt1_count", 32'(got.size()), 32'd4);
        pop_word(w); chk("pkt1_start", w, 32'h40C3000B);
        pop_word(w); chk("pkt1_data3", w, 32'h83332211);
        pop_word(w); chk("pkt1_data1", w, 32'h81000044);
        pop_word(w); chk("pkt1_end", w, 32'hC0000005);

        // rxactive pulse without bytes
        utmi_rxactive_i = 1'b1;
        step();
        utmi_rxactive_i = 1'b0;
        repeat (4) step();
        chk("empty_pkt_count", 32'(got.size()), 32'd1);
        pop_word(w); chk("empty_pkt_end", w, 32'hC0000000);

        // Line-state 00->01, then 01->10 four cycles after the first LINE
        utmi_linestate_i = 2'b01;
        step();
        repeat (3) step();
        utmi_linestate_i = 2'b10;
        repeat (6) step();
        chk("line_count", 32'(got.size()), 32'd2);
        pop_word(w); chk("line01_hdr", {16'h0, w[31:16]}, 32'h00000001);
        pop_word(w); chk("line10_word", w, 32'h00020004);

        // Stalled FIFO, 9-byte packet: four records queue, END drops
        accept_i = 1'b0;
        pkt_q = '{8'h69, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_packet();
        repeat (2) step();
        chk("ovf_push", 32'(push_o), 32'd1);
        chk("ovf_head", {16'h0, data_o[31:16]}, 32'h00004069);
        chk("ovf_flag", 32'(overflow_o), 32'd1);
        chk("ovf_drops", 32'(drop_count_o), 32'd1);
        accept_i = 1'b1;
        repeat (6) step();
        chk("ovf_drain_count", 32'(got.size()), 32'd4);
        pop_word(w); chk("ovf_start", {16'h0, w[31:16]}, 32'h00004069);
        pop_word(w); chk("ovf_d1", w, 32'h83030201);
        pop_word(w); chk("ovf_d2", w, 32'h83060504);
        pop_word(w); chk("ovf_d3", w, 32'h82000807);
        chk("ovf_push_drained", 32'(push_o), 32'd0);
        utmi_linestate_i = 2'b01;
        repeat (3) step();
        pop_word(w); chk("line_ovf_set", {16'h0, w[31:16]}, 32'h00000005);
        utmi_linestate_i = 2'b11;
        repeat (3) step();
        pop_word(w); chk("line_ovf_clr", {16'h0, w[31:16]}, 32'h00000003);
        chk("ovf_sticky", 32'(overflow_o), 32'd1);

        // rxerror on the second data byte
        pkt_q = '{8'hA5, 8'h01, 8'h02, 8'h03};
        err_idx = 2;
        run_packet();
        err_idx = -1;
        repeat (4) step();
        chk("err_count", 32'(got.size()), 32'd3);
        pop_word(w); chk("err_start", {16'h0, w[31:16]}, 32'h000040A5);
        pop_word(w); chk("err_data", w, 32'h83030201);
        pop_word(w); chk("err_end", w, 32'hC0010004);

        // Disabled capture ignores a whole packet
        enable_i = 1'b0;
        pkt_q = '{8'hA5, 8'h01};
        run_packet();
        repeat (4) step();
        enable_i = 1'b1;
        repeat (2) step();
        chk("disabled_count", 32'(got.size()), 32'd0);
        chk("disabled_push", 32'(push_o), 32'd0);

        // Reset in DATA with three records queued
        accept_i = 1'b0;
        utmi_rxactive_i = 1'b1;
        step();
        pkt_q = '{8'hE1, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        for (int i = 0; i < pkt_q.size(); i++) begin
            utmi_rxvalid_i = 1'b1;
            utmi_data_i    = pkt_q[i];
            step();
        end
        utmi_rxvalid_i = 1'b0;
        step();
        chk("pre_rst_push", 32'(push_o), 32'd1);
        chk("pre_rst_head", {16'h0, data_o[31:16]}, 32'h000040E1);
        #1;
        rst_ni           = 1'b0;
        utmi_rxactive_i  = 1'b0;
        utmi_linestate_i = 2'b00;
        accept_i         = 1'b1;
        #1;
        chk("async_rst_push", 32'(push_o), 32'd0);
        chk("async_rst_data", data_o, 32'h0);
        chk("async_rst_ovf", 32'(overflow_o), 32'd0);
        chk("async_rst_drops", 32'(drop_count_o), 32'd0);
        step();
        step();
        got.delete();
        rst_ni = 1'b1;
        step();
        pkt_q = '{8'h2D, 8'hAA};
        run_packet();
        repeat (4) step();
        chk("post_rst_count", 32'(got.size()), 32'd3);
        pop_word(w); chk("post_rst_start", w, 32'h402D0002);
        pop_word(w); chk("post_rst_data", w, 32'h810000AA);
        pop_word(w); chk("post_rst_end", w, 32'hC0000002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
